// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with commit-gated write enables and trap/mret handling.
// Optional memory wait timeout (bus-fault trap) enabled by defining MEM_TIMEOUT_EN.
module core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       rf_wen_dec,
    input  logic       csr_wen_dec,
    input  logic       mret,
    input  logic       irq_pending,
    input  logic       irq_en,
    output logic       imem_req,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_wen,
    output logic       csr_wen,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       csr_trap,
    output logic       csr_mret,
    output logic       trap_cause,
    output logic       retire,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   cause_q, cause_d;
    logic   tmo_hit;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("core_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_q, wait_d;
    logic          waiting;

    // FETCH and MEM are only ever entered from other states, so clearing
    // whenever no request is stalled is the same as clearing on entry.
    assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM)   && !dmem_ready);
    assign tmo_hit = waiting && (wait_q == CW'(TIMEOUT_CYCLES - 1));
    assign wait_d  = waiting ? wait_q + CW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = 1'b1;
                end
            end
            S_WB: begin
                if (irq_pending && irq_en) begin
                    state_d = S_TRAP;
                    cause_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_wen     = 1'b0;
        csr_wen    = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        csr_trap   = 1'b0;
        csr_mret   = 1'b0;
        trap_cause = 1'b0;
        retire     = 1'b0;
        state_o    = state_q;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            S_WB: begin
                retire  = 1'b1;
                pc_we   = 1'b1;
                rf_wen  = rf_wen_dec;
                csr_wen = csr_wen_dec;
                if (mret) begin
                    pc_src   = 2'b11;
                    csr_mret = 1'b1;
                end
            end
            S_TRAP: begin
                pc_we      = 1'b1;
                pc_src     = 2'b10;
                csr_trap   = 1'b1;
                trap_cause = cause_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction expected cycle traces built from timing rules.
module tb_core_sequencer;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_ready, dmem_ready, is_load, is_store;
    logic       rf_wen_dec, csr_wen_dec, mret, irq_pending, irq_en;
    logic       imem_req, ir_load, dmem_req, dmem_we, rf_wen, csr_wen, pc_we;
    logic [1:0] pc_src;
    logic       csr_trap, csr_mret, trap_cause, retire;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    core_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_load(is_load), .is_store(is_store),
        .rf_wen_dec(rf_wen_dec), .csr_wen_dec(csr_wen_dec), .mret(mret),
        .irq_pending(irq_pending), .irq_en(irq_en),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_wen(rf_wen), .csr_wen(csr_wen), .pc_we(pc_we), .pc_src(pc_src),
        .csr_trap(csr_trap), .csr_mret(csr_mret), .trap_cause(trap_cause),
        .retire(retire), .state_o(state_o)
    );

    typedef struct {
        logic rst_n, imr, dmr, ld, st, rf, csr, mr, irqp, irqe;
        logic [15:0] exp;
    } rec_t;

    rec_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic c_ld, c_st, c_rf, c_csr, c_mr, c_irqp, c_irqe;

    // {imem_req, ir_load, dmem_req, dmem_we, rf_wen, csr_wen, pc_we, pc_src, csr_trap, csr_mret, trap_cause, retire, state}
    function automatic logic [15:0] ev(input logic ireq, ild, dreq, dwe, rfw, csw, pcw,
                                       input logic [1:0] src, input logic trp, mrt, cs, ret,
                                       input logic [2:0] st);
        return {ireq, ild, dreq, dwe, rfw, csw, pcw, src, trp, mrt, cs, ret, st};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic rst, input logic imr, input logic dmr, input logic [15:0] exp);
        rec_t r;
        r.rst_n = rst; r.imr = imr; r.dmr = dmr;
        r.ld = c_ld; r.st = c_st; r.rf = c_rf; r.csr = c_csr; r.mr = c_mr;
        r.irqp = c_irqp; r.irqe = c_irqe; r.exp = exp;
        q.push_back(r);
    endtask

    task automatic push_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 16'h0000);
        push(1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    // Fetch waits iw, memory waits dw; abort_mem>=0 stops the trace before that memory cycle.
    task automatic add_instr(input logic ld, st, rf, csr, mr, irqp, irqe,
                             input int iw, input int dw, input int abort_mem);
        c_ld = ld; c_st = st; c_rf = rf; c_csr = csr; c_mr = mr; c_irqp = irqp; c_irqe = irqe;
`ifdef MEM_TIMEOUT_EN
        if (iw >= TMO) begin
            for (int i = 0; i < TMO; i++) push(1'b1, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,2'b00,0,0,0,0,3'd1));
            push(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,2'b10,1,0,1,0,3'd6));
            return;
        end
`endif
        for (int i = 0; i < iw; i++) push(1'b1, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,2'b00,0,0,0,0,3'd1));
        push(1'b1, 1'b1, 1'b0, ev(1,1,0,0,0,0,0,2'b00,0,0,0,0,3'd1));
        push(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,2'b00,0,0,0,0,3'd2));
        push(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,2'b00,0,0,0,0,3'd3));
        if (ld || st) begin
`ifdef MEM_TIMEOUT_EN
            if (dw >= TMO && abort_mem < 0) begin
                for (int i = 0; i < TMO; i++) push(1'b1, 1'b0, 1'b0, ev(0,0,1,st,0,0,0,2'b00,0,0,0,0,3'd4));
                push(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,2'b10,1,0,1,0,3'd6));
                return;
            end
`endif
            for (int i = 0; i < dw; i++) begin
                if (abort_mem == i) return;
                push(1'b1, 1'b0, 1'b0, ev(0,0,1,st,0,0,0,2'b00,0,0,0,0,3'd4));
            end
            push(1'b1, 1'b0, 1'b1, ev(0,0,1,st,0,0,0,2'b00,0,0,0,0,3'd4));
        end
        push(1'b1, 1'b0, 1'b0, ev(0,0,0,0,rf,csr,1,mr ? 2'b11 : 2'b00,0,mr,0,1,3'd5));
        if (irqp && irqe) push(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,2'b10,1,0,0,0,3'd6));
    endtask

    function automatic int count_dreq(input int from);
        int n = 0;
        for (int i = from; i < q.size(); i++) if (q[i].exp[13]) n++;
        return n;
    endfunction

    initial begin
        int s0;
        logic [15:0] act;
        rst_n = 1'b0; imem_ready = 0; dmem_ready = 0; is_load = 0; is_store = 0;
        rf_wen_dec = 0; csr_wen_dec = 0; mret = 0; irq_pending = 0; irq_en = 0;
        c_ld = 0; c_st = 0; c_rf = 0; c_csr = 0; c_mr = 0; c_irqp = 0; c_irqe = 0;

        push_reset(2);
        s0 = q.size(); add_instr(0,0,1,0,0,0,0, 0,0,-1);               // ADD
        chk("add_len", 16'(q.size() - s0), 16'd4);
        chk("add_wb", q[$].exp, 16'h0A0D);
        s0 = q.size(); add_instr(1,0,1,0,0,0,0, 0,3,-1);               // LW, 3 waits
        chk("lw_len", 16'(q.size() - s0), 16'd8);
        chk("lw_dreq_cycles", 16'(count_dreq(s0)), 16'd4);
        s0 = q.size(); add_instr(0,1,0,0,0,1,1, 0,0,-1);               // SW + irq
        chk("sw_irq_len", 16'(q.size() - s0), 16'd6);
        chk("sw_irq_trap", q[$].exp, 16'h0346);
        add_instr(0,0,0,0,1,0,0, 0,0,-1);                              // mret
        chk("mret_wb", q[$].exp, 16'h03AD);
        add_instr(0,0,0,1,0,0,0, 2,0,-1);                              // CSR write, fetch waits
        add_instr(0,0,1,0,0,1,0, 0,0,-1);                              // irq masked
        add_instr(0,0,0,0,1,1,1, 0,0,-1);                              // mret then trap
        add_instr(0,0,1,0,0,0,0, TMO-1,0,-1);                          // ready on limit cycle
        add_instr(0,1,0,0,0,0,0, 0,TMO-1,-1);
        add_instr(1,0,1,0,0,0,0, 0,3,1);                               // reset during MEM wait
        push_reset(1);
        add_instr(0,0,1,0,0,0,0, 1,0,-1);
`ifdef MEM_TIMEOUT_EN
        add_instr(0,0,1,0,0,0,0, TMO+2,0,-1);                          // fetch bus fault
        chk("fetch_tmo_trap", q[$].exp, 16'h0356);
        add_instr(0,1,0,0,0,0,0, 0,TMO+1,-1);                          // data bus fault
`else
        add_instr(0,0,1,0,0,0,0, 9,0,-1);
        add_instr(0,1,0,0,0,0,0, 0,7,-1);
`endif
        add_instr(1,0,1,0,0,0,0, 0,0,-1);

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rst_n = q[i].rst_n; imem_ready = q[i].imr; dmem_ready = q[i].dmr;
            is_load = q[i].ld; is_store = q[i].st; rf_wen_dec = q[i].rf;
            csr_wen_dec = q[i].csr; mret = q[i].mr; irq_pending = q[i].irqp; irq_en = q[i].irqe;
            #3;
            act = {imem_req, ir_load, dmem_req, dmem_we, rf_wen, csr_wen, pc_we, pc_src,
                   csr_trap, csr_mret, trap_cause, retire, state_o};
            chk($sformatf("cycle%0d", i), act, q[i].exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
